xor_stream_parity: RTL and testbench

Parametrised, clocked successor to the two-input XOR gate. The block XOR-accumulates a stream of WIDTH-bit words, one packet at a time, using a valid/ready handshake. At the end of each packet it delivers the bitwise XOR of all words, a configurable even/odd parity bit and a saturating beat count. It sits between a packet source and a link or check stage as a streaming parity generator.

---
 rtl/xor_stream_parity.sv | 115 +++++++++++
 tb/tb_xor_stream_parity.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/xor_stream_parity.sv
// rtl/xor_stream_parity.sv - streaming per-packet XOR accumulator with parity and saturating beat count
module xor_stream_parity #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             odd_mode,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_xor,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic             first_q, first_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] out_xor_q, out_xor_d;
  logic             out_parity_q, out_parity_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_valid_q, out_valid_d;
  logic             accept;

  assign accept = in_valid && (state_q == ACCUM);

  always_comb begin
    state_d      = state_q;
    first_d      = first_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    mode_d       = mode_q;
    out_xor_d    = out_xor_q;
    out_parity_d = out_parity_q;
    out_count_d  = out_count_q;
    out_valid_d  = out_valid_q;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          first_d = 1'b0;
          if (first_q) begin
            acc_d  = in_data;
            cnt_d  = CNT_ONE;
            mode_d = odd_mode;
          end else begin
            acc_d = acc_q ^ in_data;
            // Count pins at all-ones; the XOR keeps accumulating regardless.
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
          end
          if (in_last) begin
            out_xor_d    = acc_d;
            out_parity_d = (^acc_d) ^ mode_d;
            out_count_d  = cnt_d;
            out_valid_d  = 1'b1;
            state_d      = HOLD;
            first_d      = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
        first_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ACCUM;
      first_q      <= 1'b1;
      acc_q        <= '0;
      cnt_q        <= '0;
      mode_q       <= 1'b0;
      out_xor_q    <= '0;
      out_parity_q <= 1'b0;
      out_count_q  <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      first_q      <= first_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      out_xor_q    <= out_xor_d;
      out_parity_q <= out_parity_d;
      out_count_q  <= out_count_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign in_ready   = (state_q == ACCUM);
  assign out_xor    = out_xor_q;
  assign out_parity = out_parity_q;
  assign out_count  = out_count_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_xor_stream_parity.sv
// tb/tb_xor_stream_parity.sv - directed bench for xor_stream_parity (default widths and CNT_W=2)
module tb_xor_stream_parity;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       odd_mode;
  logic       out_ready;

  logic       in_ready_a, out_parity_a, out_valid_a;
  logic [7:0] out_xor_a, out_count_a;
  logic       in_ready_b, out_parity_b, out_valid_b;
  logic [7:0] out_xor_b;
  logic [1:0] out_count_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  xor_stream_parity #(.WIDTH(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .odd_mode(odd_mode), .in_ready(in_ready_a),
    .out_xor(out_xor_a), .out_parity(out_parity_a), .out_count(out_count_a),
    .out_valid(out_valid_a), .out_ready(out_ready)
  );

  xor_stream_parity #(.WIDTH(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .odd_mode(odd_mode), .in_ready(in_ready_b),
    .out_xor(out_xor_b), .out_parity(out_parity_b), .out_count(out_count_b),
    .out_valid(out_valid_b), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic last, input logic om);
    in_data  = d;
    in_last  = last;
    odd_mode = om;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic [7:0] x, input logic p, input logic [7:0] c);
    chk({tag, "_valid"},  32'(out_valid_a),  32'd1);
    chk({tag, "_xor"},    32'(out_xor_a),    32'(x));
    chk({tag, "_parity"}, 32'(out_parity_a), 32'(p));
    chk({tag, "_count"},  32'(out_count_a),  32'(c));
    chk({tag, "_ready"},  32'(in_ready_a),   32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},  32'(in_ready_a),   32'd1);
    chk({tag, "_valid"},  32'(out_valid_a),  32'd0);
    chk({tag, "_xor"},    32'(out_xor_a),    32'd0);
    chk({tag, "_parity"}, 32'(out_parity_a), 32'd0);
    chk({tag, "_count"},  32'(out_count_a),  32'd0);
    chk({tag, "_b_valid"}, 32'(out_valid_b), 32'd0);
    chk({tag, "_b_count"}, 32'(out_count_b), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    odd_mode = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();

    // single beat A5, even
    beat(8'hA5, 1'b1, 1'b0);
    chk_result("single", 8'hA5, 1'b0, 8'd1);
    out_ready = 1'b1;
    tick();
    chk("single_release_valid", 32'(out_valid_a), 32'd0);
    chk("single_release_ready", 32'(in_ready_a), 32'd1);
    out_ready = 1'b0;

    // 0F,F0,01 odd mode from first beat only
    beat(8'h0F, 1'b0, 1'b1);
    beat(8'hF0, 1'b0, 1'b0);
    beat(8'h01, 1'b1, 1'b0);
    chk_result("three", 8'hFE, 1'b0, 8'd3);

    // backpressure with new data offered
    in_data = 8'h55; in_last = 1'b1; odd_mode = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_result("bp", 8'hFE, 1'b0, 8'd3);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(out_valid_a), 32'd0);
    chk("bp_release_ready", 32'(in_ready_a), 32'd1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk_result("bp_next", 8'h55, 1'b0, 8'd1);
    tick();
    chk("bp_next_release", 32'(out_valid_a), 32'd0);

    // gaps inside a packet
    beat(8'h11, 1'b0, 1'b0);
    tick(); tick(); tick();
    chk("gap_no_valid", 32'(out_valid_a), 32'd0);
    chk("gap_ready", 32'(in_ready_a), 32'd1);
    beat(8'h22, 1'b1, 1'b0);
    chk_result("gap", 8'h33, 1'b0, 8'd2);
    tick();

    // saturation: five beats of 01
    for (int i = 0; i < 4; i++) beat(8'h01, 1'b0, 1'b0);
    beat(8'h01, 1'b1, 1'b0);
    chk_result("sat_a", 8'h01, 1'b1, 8'd5);
    chk("sat_b_valid",  32'(out_valid_b),  32'd1);
    chk("sat_b_xor",    32'(out_xor_b),    32'h01);
    chk("sat_b_parity", 32'(out_parity_b), 32'd1);
    chk("sat_b_count",  32'(out_count_b),  32'd3);
    tick();

    // asynchronous reset mid-packet
    beat(8'h77, 1'b0, 1'b1);
    beat(8'h88, 1'b0, 1'b0);
    chk("abort_pre_valid", 32'(out_valid_a), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("abort_async");
    tick();
    rst = 1'b0;
    tick();
    chk("abort_post_valid", 32'(out_valid_a), 32'd0);
    beat(8'h3C, 1'b1, 1'b0);
    chk_result("abort_next", 8'h3C, 1'b0, 8'd1);
    tick();
    chk("final_valid", 32'(out_valid_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
